// File: rtl/tg68k_fpu_pkg.sv
// Shared types and constants for the FPU fetch/decode front end:
// sequencer state encoding, decoder instruction_type codes and default vectors.
package tg68k_fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREDEC    = 3'd1,
        ST_FETCH_EXT = 3'd2,
        ST_DECODE    = 3'd3,
        ST_DISPATCH  = 3'd4,
        ST_EXC       = 3'd5
    } fetch_state_t;

    localparam logic [3:0] ITYPE_NONE       = 4'b0000;
    localparam logic [3:0] ITYPE_GENERAL    = 4'b0001;
    localparam logic [3:0] ITYPE_FSAVE      = 4'b0010;
    localparam logic [3:0] ITYPE_FMOVEM     = 4'b0011;
    localparam logic [3:0] ITYPE_FRESTORE   = 4'b0100;
    localparam logic [3:0] ITYPE_FSCC       = 4'b0101;
    localparam logic [3:0] ITYPE_FBCC16     = 4'b0110;
    localparam logic [3:0] ITYPE_FBCC32     = 4'b0111;
    localparam logic [3:0] ITYPE_FTRAPCC    = 4'b1000;
    localparam logic [3:0] ITYPE_FMOVEM_CTL = 4'b1001;

    localparam int         EXT_TIMEOUT_DEF = 255;
    localparam logic [7:0] VEC_FLINE_DEF   = 8'd11;
    localparam logic [7:0] VEC_PRIV_DEF    = 8'd8;
    localparam logic [7:0] VEC_BUSERR_DEF  = 8'd2;

    // A decoded word is an F-line fault if flagged illegal or it decodes to no type.
    function automatic logic is_fline_fault(input logic illegal, input logic [3:0] itype);
        return illegal || (itype == ITYPE_NONE);
    endfunction

endpackage

// File: rtl/tg68k_fpu_ext_timer.sv
// Loadable down-counter guarding the extension-word fetch; expire flags the
// last permitted wait cycle (count == 1).
module tg68k_fpu_ext_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/tg68k_fpu_fetch_sequencer.sv
// Front end of the FPU decoder: accepts an F-line opcode, optionally fetches the
// extension word, runs one decode cycle and hands off to dispatch or exception.
module tg68k_fpu_fetch_sequencer
    import tg68k_fpu_pkg::*;
#(
    parameter int         EXT_TIMEOUT = EXT_TIMEOUT_DEF,
    parameter logic [7:0] VEC_FLINE   = VEC_FLINE_DEF,
    parameter logic [7:0] VEC_PRIV    = VEC_PRIV_DEF,
    parameter logic [7:0] VEC_BUSERR  = VEC_BUSERR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fline_valid,
    input  logic [15:0] fline_opcode,
    output logic        fline_ack,
    output logic        ext_req,
    input  logic        ext_ack,
    input  logic [15:0] ext_data,
    input  logic        abort,
    input  logic        supervisor,
    output logic [15:0] dec_opcode,
    output logic [15:0] dec_ext,
    output logic        dec_enable,
    input  logic        dec_needs_ext,
    input  logic        dec_valid,
    input  logic        dec_illegal,
    input  logic        dec_priv,
    input  logic [3:0]  dec_type,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic [15:0] disp_opcode,
    output logic [15:0] disp_ext,
    output logic [3:0]  disp_type,
    output logic        exc_valid,
    output logic [7:0]  exc_vector,
    input  logic        exc_ack,
    output logic        busy
);

    localparam logic [7:0] TIMEOUT_LOAD = 8'(EXT_TIMEOUT);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [15:0] r_op;
    logic [15:0] r_ext;
    logic [15:0] r_disp_opcode;
    logic [15:0] r_disp_ext;
    logic [3:0]  r_disp_type;
    logic [7:0]  r_exc_vector;

    logic       w_fline_ack;
    logic       w_ext_req;
    logic       w_dec_enable;
    logic       w_op_load;
    logic       w_ext_clear;
    logic       w_ext_load;
    logic       w_disp_load;
    logic       w_exc_load;
    logic [7:0] w_exc_vec_next;
    logic       w_tmr_load;
    logic       w_tmr_dec;
    logic       w_tmr_expire;

    // The decoder's valid flag is redundant with illegal/type here.
    logic w_unused;
    assign w_unused = dec_valid;

    tg68k_fpu_ext_timer #(
        .WIDTH (8)
    ) u_ext_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_tmr_load),
        .i_load_value (TIMEOUT_LOAD),
        .i_dec        (w_tmr_dec),
        .o_expire     (w_tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_fline_ack    = 1'b0;
        w_ext_req      = 1'b0;
        w_dec_enable   = 1'b0;
        w_op_load      = 1'b0;
        w_ext_clear    = 1'b0;
        w_ext_load     = 1'b0;
        w_disp_load    = 1'b0;
        w_exc_load     = 1'b0;
        w_exc_vec_next = r_exc_vector;
        w_tmr_load     = 1'b0;
        w_tmr_dec      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (fline_valid) begin
                    w_fline_ack  = 1'b1;
                    w_op_load    = 1'b1;
                    w_ext_clear  = 1'b1;
                    w_state_next = ST_PREDEC;
                end
            end
            ST_PREDEC: begin
                if (dec_needs_ext) begin
                    w_tmr_load   = 1'b1;
                    w_state_next = ST_FETCH_EXT;
                end else begin
                    w_ext_clear  = 1'b1;
                    w_state_next = ST_DECODE;
                end
            end
            ST_FETCH_EXT: begin
                w_ext_req = 1'b1;
                // A late ack still wins over the expiring timer.
                if (ext_ack) begin
                    w_ext_load   = 1'b1;
                    w_state_next = ST_DECODE;
                end else if (w_tmr_expire) begin
                    w_exc_load     = 1'b1;
                    w_exc_vec_next = VEC_BUSERR;
                    w_state_next   = ST_EXC;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_DECODE: begin
                w_dec_enable = 1'b1;
                if (is_fline_fault(dec_illegal, dec_type)) begin
                    w_exc_load     = 1'b1;
                    w_exc_vec_next = VEC_FLINE;
                    w_state_next   = ST_EXC;
                end else if (dec_priv && !supervisor) begin
                    w_exc_load     = 1'b1;
                    w_exc_vec_next = VEC_PRIV;
                    w_state_next   = ST_EXC;
                end else begin
                    w_disp_load  = 1'b1;
                    w_state_next = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (disp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_EXC: begin
                if (exc_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Flush cancels every side effect of this cycle, including a same-cycle ack.
        if (abort) begin
            w_state_next = ST_IDLE;
            w_fline_ack  = 1'b0;
            w_op_load    = 1'b0;
            w_ext_clear  = 1'b0;
            w_ext_load   = 1'b0;
            w_disp_load  = 1'b0;
            w_exc_load   = 1'b0;
            w_tmr_load   = 1'b0;
            w_tmr_dec    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op          <= '0;
            r_ext         <= '0;
            r_disp_opcode <= '0;
            r_disp_ext    <= '0;
            r_disp_type   <= '0;
            r_exc_vector  <= '0;
        end else begin
            if (w_op_load) begin
                r_op <= fline_opcode;
            end
            if (w_ext_clear) begin
                r_ext <= '0;
            end else if (w_ext_load) begin
                r_ext <= ext_data;
            end
            if (w_disp_load) begin
                r_disp_opcode <= r_op;
                r_disp_ext    <= r_ext;
                r_disp_type   <= dec_type;
            end
            if (w_exc_load) begin
                r_exc_vector <= w_exc_vec_next;
            end
        end
    end

    assign fline_ack   = w_fline_ack;
    assign ext_req     = w_ext_req;
    assign dec_enable  = w_dec_enable;
    assign dec_opcode  = r_op;
    assign dec_ext     = r_ext;
    assign disp_valid  = (r_state == ST_DISPATCH);
    assign disp_opcode = r_disp_opcode;
    assign disp_ext    = r_disp_ext;
    assign disp_type   = r_disp_type;
    assign exc_valid   = (r_state == ST_EXC);
    assign exc_vector  = r_exc_vector;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tg68k_fpu_fetch_sequencer.sv
// Directed bench for the FPU fetch sequencer with a tiny stand-in decoder.
module tb_tg68k_fpu_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fline_valid;
    logic [15:0] fline_opcode;
    logic        fline_ack;
    logic        ext_req;
    logic        ext_ack;
    logic [15:0] ext_data;
    logic        abort;
    logic        supervisor;
    logic [15:0] dec_opcode;
    logic [15:0] dec_ext;
    logic        dec_enable;
    logic        dec_needs_ext;
    logic        dec_valid;
    logic        dec_illegal;
    logic        dec_priv;
    logic [3:0]  dec_type;
    logic        disp_valid;
    logic        disp_ready;
    logic [15:0] disp_opcode;
    logic [15:0] disp_ext;
    logic [3:0]  disp_type;
    logic        exc_valid;
    logic [7:0]  exc_vector;
    logic        exc_ack;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int req_cycles  = 0;
    int en_pulses   = 0;
    int base_req;
    int base_en;

    tg68k_fpu_fetch_sequencer #(
        .EXT_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fline_valid   (fline_valid),
        .fline_opcode  (fline_opcode),
        .fline_ack     (fline_ack),
        .ext_req       (ext_req),
        .ext_ack       (ext_ack),
        .ext_data      (ext_data),
        .abort         (abort),
        .supervisor    (supervisor),
        .dec_opcode    (dec_opcode),
        .dec_ext       (dec_ext),
        .dec_enable    (dec_enable),
        .dec_needs_ext (dec_needs_ext),
        .dec_valid     (dec_valid),
        .dec_illegal   (dec_illegal),
        .dec_priv      (dec_priv),
        .dec_type      (dec_type),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_opcode   (disp_opcode),
        .disp_ext      (disp_ext),
        .disp_type     (disp_type),
        .exc_valid     (exc_valid),
        .exc_vector    (exc_vector),
        .exc_ack       (exc_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Stand-in decoder keyed on opcode bits 8:6: 000 general (needs ext),
    // 010 FBcc16, 101 FRESTORE (privileged), anything else undecodable.
    always_comb begin
        dec_needs_ext = 1'b0;
        dec_priv      = 1'b0;
        dec_type      = 4'b0000;
        case (dec_opcode[8:6])
            3'b000: begin dec_needs_ext = 1'b1; dec_type = 4'b0001; end
            3'b010: dec_type = 4'b0110;
            3'b101: begin dec_type = 4'b0100; dec_priv = 1'b1; end
            default: dec_type = 4'b0000;
        endcase
        dec_illegal = (dec_opcode[8:6] == 3'b000) && (dec_ext[6:0] == 7'h30);
        dec_valid   = !dec_illegal && (dec_type != 4'b0000);
    end

    always @(posedge clk) begin
        if (ext_req)    req_cycles <= req_cycles + 1;
        if (dec_enable) en_pulses  <= en_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; fline_valid = 1'b0; fline_opcode = '0; ext_ack = 1'b0;
        ext_data = '0; abort = 1'b0; supervisor = 1'b0; disp_ready = 1'b0; exc_ack = 1'b0;
        step; step; #1;
        chk("rst_busy", busy, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_exc_valid", exc_valid, 0);
        chk("rst_ext_req", ext_req, 0);
        chk("rst_dec_enable", dec_enable, 0);
        chk("rst_dec_opcode", dec_opcode, 0);
        chk("rst_exc_vector", exc_vector, 0);
        chk("rst_disp_type", disp_type, 0);
        reset = 1'b0;

        // F200 + ext 0x0422, ack on the 4th fetch cycle (counter at 1: ack wins)
        step; fline_valid = 1'b1; fline_opcode = 16'hF200; #1;
        chk("t1_fline_ack", fline_ack, 1);
        base_req = req_cycles; base_en = en_pulses;
        step; fline_valid = 1'b0; #1;
        chk("t1_predec_busy", busy, 1);
        chk("t1_predec_ext_req", ext_req, 0);
        chk("t1_dec_opcode", dec_opcode, 16'hF200);
        for (int i = 0; i < 3; i++) begin
            step; #1;
            chk("t1_ext_req_wait", ext_req, 1);
        end
        step; ext_ack = 1'b1; ext_data = 16'h0422; #1;
        chk("t1_ext_req_ack", ext_req, 1);
        step; ext_ack = 1'b0; ext_data = 16'h0; #1;
        chk("t1_dec_enable", dec_enable, 1);
        chk("t1_ext_req_drop", ext_req, 0);
        chk("t1_dec_ext", dec_ext, 16'h0422);
        step; disp_ready = 1'b1; #1;
        chk("t1_disp_valid", disp_valid, 1);
        chk("t1_disp_ext", disp_ext, 16'h0422);
        chk("t1_disp_type", disp_type, 4'b0001);
        chk("t1_disp_opcode", disp_opcode, 16'hF200);
        chk("t1_dec_enable_off", dec_enable, 0);
        step; disp_ready = 1'b0; #1;
        chk("t1_disp_drop", disp_valid, 0);
        chk("t1_idle", busy, 0);
        chk("t1_req_burst", req_cycles - base_req, 4);
        chk("t1_en_pulses", en_pulses - base_en, 1);

        // F280 FBcc16: no extension, ready held low 5 cycles
        step; fline_valid = 1'b1; fline_opcode = 16'hF280; #1;
        chk("t2_fline_ack", fline_ack, 1);
        base_req = req_cycles;
        step; fline_valid = 1'b0; #1;
        step; #1;
        chk("t2_dec_enable", dec_enable, 1);
        for (int i = 0; i < 5; i++) begin
            step; fline_valid = (i == 0); fline_opcode = 16'hF200; #1;
            chk("t2_disp_valid_hold", disp_valid, 1);
            chk("t2_disp_type", disp_type, 4'b0110);
            chk("t2_disp_opcode", disp_opcode, 16'hF280);
            chk("t2_fline_ignored", fline_ack, 0);
        end
        step; disp_ready = 1'b1; #1;
        chk("t2_disp_valid_xfer", disp_valid, 1);
        step; disp_ready = 1'b0; #1;
        chk("t2_disp_drop", disp_valid, 0);
        chk("t2_idle", busy, 0);
        chk("t2_no_ext_req", req_cycles - base_req, 0);

        // F340 FRESTORE in user mode -> privilege violation
        step; fline_valid = 1'b1; fline_opcode = 16'hF340; supervisor = 1'b0; #1;
        step; fline_valid = 1'b0; #1;
        step; #1;
        step; #1;
        chk("t3_exc_valid", exc_valid, 1);
        chk("t3_exc_vector", exc_vector, 8'd8);
        chk("t3_no_disp", disp_valid, 0);
        step; exc_ack = 1'b1; #1;
        chk("t3_exc_hold", exc_valid, 1);
        chk("t3_exc_vector_hold", exc_vector, 8'd8);
        step; exc_ack = 1'b0; #1;
        chk("t3_exc_drop", exc_valid, 0);
        chk("t3_idle", busy, 0);

        // Same opcode in supervisor mode dispatches
        step; fline_valid = 1'b1; fline_opcode = 16'hF340; supervisor = 1'b1; #1;
        step; fline_valid = 1'b0; #1;
        step; #1;
        step; disp_ready = 1'b1; #1;
        chk("t3b_disp_valid", disp_valid, 1);
        chk("t3b_disp_type", disp_type, 4'b0100);
        chk("t3b_no_exc", exc_valid, 0);
        step; disp_ready = 1'b0; supervisor = 1'b0; #1;
        chk("t3b_idle", busy, 0);

        // F200 with no ext_ack: bus error after 4 fetch cycles
        step; fline_valid = 1'b1; fline_opcode = 16'hF200; #1;
        step; fline_valid = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            step; #1;
            chk("t4_ext_req", ext_req, 1);
            chk("t4_no_exc_yet", exc_valid, 0);
        end
        step; #1;
        chk("t4_exc_valid", exc_valid, 1);
        chk("t4_exc_vector", exc_vector, 8'd2);
        chk("t4_ext_req_drop", ext_req, 0);
        exc_ack = 1'b1;
        step; exc_ack = 1'b0; #1;
        chk("t4_idle", busy, 0);

        // F200 with illegal opmode 0x30 -> F-line
        step; fline_valid = 1'b1; fline_opcode = 16'hF200; #1;
        step; fline_valid = 1'b0; #1;
        step; ext_ack = 1'b1; ext_data = 16'h0030; #1;
        step; ext_ack = 1'b0; ext_data = 16'h0; #1;
        chk("t5_dec_enable", dec_enable, 1);
        chk("t5_dec_ext", dec_ext, 16'h0030);
        step; exc_ack = 1'b1; #1;
        chk("t5_exc_valid", exc_valid, 1);
        chk("t5_exc_vector", exc_vector, 8'd11);
        chk("t5_no_disp", disp_valid, 0);
        step; exc_ack = 1'b0; #1;
        chk("t5_idle", busy, 0);
        chk("t5_no_disp_after", disp_valid, 0);

        // F3C0 decodes to type 0 -> F-line
        step; fline_valid = 1'b1; fline_opcode = 16'hF3C0; #1;
        step; fline_valid = 1'b0; #1;
        step; #1;
        step; exc_ack = 1'b1; #1;
        chk("t5b_exc_vector", exc_vector, 8'd11);
        chk("t5b_no_disp", disp_valid, 0);
        step; exc_ack = 1'b0; #1;
        chk("t5b_idle", busy, 0);

        // Abort during FETCH_EXT coinciding with ext_ack, then a new opcode
        base_en = en_pulses;
        step; fline_valid = 1'b1; fline_opcode = 16'hF200; #1;
        step; fline_valid = 1'b0; #1;
        step; abort = 1'b1; ext_ack = 1'b1; ext_data = 16'h1234; #1;
        chk("t6_ext_req_abort", ext_req, 1);
        chk("t6_abort_no_dec", dec_enable, 0);
        step; abort = 1'b0; ext_ack = 1'b0; ext_data = 16'h0;
        fline_valid = 1'b1; fline_opcode = 16'hF280; #1;
        chk("t6_idle", busy, 0);
        chk("t6_ext_req_drop", ext_req, 0);
        chk("t6_ext_not_latched", dec_ext, 16'h0000);
        chk("t6_new_fline_ack", fline_ack, 1);
        step; fline_valid = 1'b0; #1;
        chk("t6_dec_opcode", dec_opcode, 16'hF280);
        step; #1;
        step; disp_ready = 1'b1; #1;
        chk("t6_disp_valid", disp_valid, 1);
        chk("t6_disp_opcode", disp_opcode, 16'hF280);
        chk("t6_disp_ext", disp_ext, 16'h0000);
        chk("t6_disp_type", disp_type, 4'b0110);
        step; disp_ready = 1'b0; #1;
        chk("t6_idle_end", busy, 0);
        chk("t6_en_pulses", en_pulses - base_en, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tg68k_fpu_fetch_sequencer.md
Name: tg68k_fpu_fetch_sequencer

Overview:
Upstream stage of the FPU instruction decoder. It accepts an F-line opcode from the TG68K main decode and fetches the coprocessor extension word from the prefetch path when one is needed. It then drives the decoder with a stable opcode/extension pair plus a one-cycle decode enable, and routes the result either to FPU dispatch (valid/ready) or to exception entry. One instruction is in flight at a time.

Parameters:
EXT_TIMEOUT, 255, cycles to wait for ext_ack before raising a bus-error exception (8-bit counter, 1..255)
VEC_FLINE, 8'd11, vector for an illegal or unimplemented F-line instruction
VEC_PRIV, 8'd8, vector for a privilege violation
VEC_BUSERR, 8'd2, vector for an extension-fetch timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fline_valid  in  1  main decode presents an F-line opcode
fline_opcode  in  16  opcode word
fline_ack  out  1  one-cycle pulse: opcode accepted
ext_req  out  1  request next instruction word from prefetch
ext_ack  in  1  ext_data valid this cycle
ext_data  in  16  extension word
abort  in  1  flush, e.g. on interrupt or branch; highest priority
supervisor  in  1  SR.S bit
dec_opcode  out  16  to decoder opcode
dec_ext  out  16  to decoder extension_word
dec_enable  out  1  to decoder decode_enable
dec_needs_ext  in  1  decoder needs_extension_word; opcode-only combinational
dec_valid  in  1  decoder valid_instruction
dec_illegal  in  1  decoder illegal_instruction
dec_priv  in  1  decoder privileged_instruction
dec_type  in  4  decoder instruction_type
disp_valid  out  1  decoded instruction available to FPU execute
disp_ready  in  1  FPU execute accepts
disp_opcode  out  16  latched opcode
disp_ext  out  16  latched extension word
disp_type  out  4  latched instruction type
exc_valid  out  1  exception request to CPU
exc_vector  out  8  vector number
exc_ack  in  1  exception accepted
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, PREDEC, FETCH_EXT, DECODE, DISPATCH, EXC.
- Reset values: state IDLE. All outputs 0, including opcode/ext/type/vector registers. The timeout counter is 0.
- IDLE, fline_valid=1: latch fline_opcode into op_r; pulse fline_ack for that cycle; clear ext_r; go to PREDEC. fline_valid is ignored in all other states.
- PREDEC: dec_opcode=op_r and dec_enable=0. Sample dec_needs_ext.
  - 1: go to FETCH_EXT and load the counter with EXT_TIMEOUT.
  - 0: go to DECODE with ext_r=0.
- FETCH_EXT: ext_req=1 is asserted combinationally in this state.
  - ext_ack=1: latch ext_data into ext_r; go to DECODE. ext_req drops the next cycle.
  - Otherwise the counter decrements. When the counter is 1 and there is no ack, go to EXC with VEC_BUSERR.
  - ext_ack in the same cycle the counter expires: the ack wins.
- DECODE: dec_enable=1 for exactly one cycle. Sample the decoder outputs in the same cycle, in this priority order:
  1. dec_illegal: EXC with VEC_FLINE.
  2. dec_type==0: EXC with VEC_FLINE.
  3. dec_priv & ~supervisor: EXC with VEC_PRIV.
  4. Otherwise: latch dec_type and go to DISPATCH.
- DISPATCH: hold disp_valid=1 with stable disp_* until disp_ready=1. The transfer happens on the cycle both are high; the next cycle is IDLE. disp_valid can be high for 1 cycle minimum.
- EXC: hold exc_valid and exc_vector until exc_ack; then IDLE.
- dec_opcode/dec_ext mirror op_r/ext_r in all states.
- abort=1 in any state: next state IDLE. disp_valid, exc_valid and ext_req deassert the next cycle. A same-cycle disp_ready, exc_ack or ext_ack is ignored and no transfer is counted.
- Minimum latency, no extension word and disp_ready tied high: fline_ack at T0, disp_valid at T3, IDLE at T4.

Decomposition:
- Package tg68k_fpu_pkg holds:
  - the state encoding, as a 3-bit enum;
  - the instruction_type constants (0000 none, 0001 general, 0011 FMOVEM, 0101 FScc/FDBcc, 0110 FBcc16, 0111 FBcc32, 1000 FTRAPcc, 1001 FMOVEM ctl, 0100 FRESTORE, 0010 FSAVE);
  - the vector default constants.
- One natural sub-module, tg68k_fpu_ext_timer: a loadable down-counter with an expire flag. The FSM stays in the top level.

Test Plan:
- Opcode F200 with ext 0x0422 (FADD FP1,FP0), ext_ack after 3 cycles, disp_ready=1 → one ext_req burst of 4 cycles; disp_valid with disp_ext=0x0422 and disp_type=0001; one dec_enable pulse.
- Opcode F280 (FBcc16, no extension word), disp_ready held low 5 cycles → no ext_req; disp_valid held stable 5 cycles and dropped the cycle after ready; disp_type=0110.
- Opcode F340 (FRESTORE) with supervisor=0 → exc_valid, exc_vector=8; after exc_ack, busy=0.
- Opcode F200, ext_ack never arrives, EXT_TIMEOUT=4 → exc_vector=2 exactly 4 cycles after entering FETCH_EXT; ext_req deasserted.
- Opcode F200 with ext opmode 0x30 (decoder asserts illegal) → exc_vector=11; disp_valid never rises.
- Abort during FETCH_EXT, coinciding with ext_ack → IDLE next cycle, no dispatch, ext_r not used; a new fline_valid the cycle after is accepted normally.
